// File: rtl/accum_dump.sv
// Sweeps every accumulator address through the 1-cycle read port and streams the entries out
// on valid/ready. Entries with a zero count can be dropped.
module accum_dump #(
    parameter int ADDR_WIDTH = 14,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_addr,
    input  logic [63:0] rd_q,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [63:0] m_data,
    output logic [31:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   scan_q;
    logic [ADDR_WIDTH-1:0]   iss_addr_q;
    logic                    inflight_q;
    logic [1:0]              occ_q;
    logic [ADDR_WIDTH-1:0]   addr0_q, addr1_q;
    logic [63:0]             data0_q, data1_q;
    logic [31:0]             count_q;

    logic                    issue;
    logic                    sweep_start;
    logic                    pop;
    logic                    push;
    logic                    credit_ok;

    assign pop  = m_valid && m_ready;
    assign push = inflight_q && !(SKIP_ZERO && (rd_q[31:0] == 32'd0));

    // FIFO entries plus the read still in flight may never exceed the two slots.
    assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        sweep_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    sweep_start = 1'b1;
                end
            end
            SCAN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (scan_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q     <= '0;
            iss_addr_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            inflight_q <= issue;
            if (sweep_start) begin
                scan_q <= '0;
            end else if (issue) begin
                scan_q     <= scan_q + 1'b1;
                iss_addr_q <= scan_q;
            end
            if (sweep_start) begin
                count_q <= 32'd0;
            end else if (pop) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Two-slot shift FIFO: slot 0 is always the head driving the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= 2'd0;
            addr0_q <= '0;
            addr1_q <= '0;
            data0_q <= 64'd0;
            data1_q <= 64'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        addr0_q <= iss_addr_q;
                        data0_q <= rd_q;
                    end else begin
                        addr1_q <= iss_addr_q;
                        data1_q <= rd_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    addr0_q <= addr1_q;
                    data0_q <= data1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        addr0_q <= iss_addr_q;
                        data0_q <= rd_q;
                    end else begin
                        addr0_q <= addr1_q;
                        data0_q <= data1_q;
                        addr1_q <= iss_addr_q;
                        data1_q <= rd_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state_q == SCAN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign rd_addr = {{(32-ADDR_WIDTH){1'b0}}, scan_q};
    assign m_valid = (occ_q != 2'd0);
    assign m_addr  = {{(32-ADDR_WIDTH){1'b0}}, addr0_q};
    assign m_data  = data0_q;
    assign count   = count_q;

endmodule

// File: tb/tb_accum_dump.sv
// Drives two accum_dump instances (SKIP_ZERO=0 and 1) from shared controls, each with its own
// 1-cycle memory, and checks them against the expected beat list derived from memory contents.
module tb_accum_dump;

    localparam int AW = 4;
    localparam int N  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        m_ready;
    logic        busy    [2];
    logic        done    [2];
    logic [31:0] rd_addr [2];
    logic [63:0] rd_q    [2];
    logic        m_valid [2];
    logic [31:0] m_addr  [2];
    logic [63:0] m_data  [2];
    logic [31:0] count   [2];

    logic [63:0] mem [2][N];

    int n_chk = 0;
    int n_err = 0;

    // Reference beat lists and monitor state, one per instance.
    logic [31:0] exp_a [2][N];
    logic [63:0] exp_d [2][N];
    int          exp_n [2];
    int          got_n [2];
    int          done_n [2];
    int          done_cyc [2];
    int          last_pop [2];
    logic        hold_v [2];
    logic [31:0] hold_a [2];
    logic [63:0] hold_d [2];
    int          cyc;
    logic        mon_en = 1'b0;
    logic        rand_rdy = 1'b0;

    always #5 clk = ~clk;

    accum_dump #(.ADDR_WIDTH(AW), .SKIP_ZERO(1'b0)) u_dut_keep (
        .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
        .rd_addr(rd_addr[0]), .rd_q(rd_q[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
        .m_addr(m_addr[0]), .m_data(m_data[0]), .count(count[0])
    );

    accum_dump #(.ADDR_WIDTH(AW), .SKIP_ZERO(1'b1)) u_dut_skip (
        .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
        .rd_addr(rd_addr[1]), .rd_q(rd_q[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
        .m_addr(m_addr[1]), .m_data(m_data[1]), .count(count[1])
    );

    always @(posedge clk) begin
        rd_q[0] <= mem[0][rd_addr[0][AW-1:0]];
        rd_q[1] <= mem[1][rd_addr[1][AW-1:0]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (hold_v[i]) begin
                    check_eq("stall_valid", 64'(m_valid[i]), 64'd1);
                    check_eq("stall_addr", 64'(m_addr[i]), 64'(hold_a[i]));
                    check_eq("stall_data", m_data[i], hold_d[i]);
                end
                hold_v[i] = m_valid[i] && !m_ready;
                hold_a[i] = m_addr[i];
                hold_d[i] = m_data[i];
                if (!rand_rdy) begin
                    check_eq("busy_window", 64'(busy[i]), 64'(cyc >= 1 && cyc <= N + 2));
                    if (cyc >= 1 && cyc <= N)
                        check_eq("rd_addr_seq", 64'(rd_addr[i]), 64'(cyc - 1));
                end
                if (m_valid[i] && m_ready) begin
                    check_eq("beat_in_range", 64'(got_n[i] < exp_n[i]), 64'd1);
                    if (got_n[i] < exp_n[i]) begin
                        check_eq("beat_addr", 64'(m_addr[i]), 64'(exp_a[i][got_n[i]]));
                        check_eq("beat_data", m_data[i], exp_d[i][got_n[i]]);
                    end
                    if (!rand_rdy)
                        check_eq("beat_cycle", 64'(cyc), 64'(m_addr[i]) + 64'd3);
                    got_n[i]++;
                    last_pop[i] = cyc;
                end
                if (done[i]) begin
                    done_n[i]++;
                    done_cyc[i] = cyc;
                    check_eq("busy_at_done", 64'(busy[i]), 64'd0);
                    if (!rand_rdy)
                        check_eq("done_cycle", 64'(cyc), 64'(N + 3));
                    else if (exp_n[i] > 0 && exp_a[i][exp_n[i]-1] == 32'(N - 1))
                        check_eq("done_after_last", 64'(cyc), 64'(last_pop[i] + 1));
                    else
                        check_eq("done_late", 64'(cyc > last_pop[i]), 64'd1);
                end
            end
        end
    end

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            if ($urandom_range(9, 0) < 4) v[31:0] = 32'd0;
            mem[0][k] = v;
            mem[1][k] = v;
        end
    endtask

    task automatic sweep(input bit rnd, input bit extra);
        for (int i = 0; i < 2; i++) begin
            exp_n[i] = 0;
            for (int k = 0; k < N; k++) begin
                if (i == 0 || mem[i][k][31:0] != 32'd0) begin
                    exp_a[i][exp_n[i]] = 32'(k);
                    exp_d[i][exp_n[i]] = mem[i][k];
                    exp_n[i]++;
                end
            end
            got_n[i]    = 0;
            done_n[i]   = 0;
            done_cyc[i] = 0;
            last_pop[i] = 0;
            hold_v[i]   = 1'b0;
        end
        @(posedge clk); #1;
        rand_rdy = rnd;
        cyc      = 0;
        start    = 1'b1;
        m_ready  = 1'b1;
        mon_en   = 1'b1;
        for (int t = 1; t < 600; t++) begin
            @(posedge clk); #1;
            cyc     = t;
            start   = extra && (t == 5 || t == N + 3);
            m_ready = rnd ? ($urandom_range(9, 0) >= 3) : 1'b1;
            if (done_n[0] > 0 && done_n[1] > 0 && t > done_cyc[0] + 3 && t > done_cyc[1] + 3)
                break;
        end
        mon_en  = 1'b0;
        start   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_eq("done_once", 64'(done_n[i]), 64'd1);
            check_eq("beat_total", 64'(got_n[i]), 64'(exp_n[i]));
            check_eq("count_final", 64'(count[i]), 64'(exp_n[i]));
            check_eq("idle_busy", 64'(busy[i]), 64'd0);
        end
    endtask

    task automatic reset_mid_sweep();
        @(posedge clk); #1;
        start = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (t == 8) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_mid_busy", 64'(busy[i]), 64'd0);
            check_eq("rst_mid_valid", 64'(m_valid[i]), 64'd0);
            check_eq("rst_mid_count", 64'(count[i]), 64'd0);
            check_eq("rst_mid_rdaddr", 64'(rd_addr[i]), 64'd0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
        cyc     = 0;
        for (int k = 0; k < N; k++) begin
            mem[0][k] = 64'd0;
            mem[1][k] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_busy", 64'(busy[i]), 64'd0);
            check_eq("rst_done", 64'(done[i]), 64'd0);
            check_eq("rst_valid", 64'(m_valid[i]), 64'd0);
            check_eq("rst_rdaddr", 64'(rd_addr[i]), 64'd0);
            check_eq("rst_maddr", 64'(m_addr[i]), 64'd0);
            check_eq("rst_mdata", m_data[i], 64'd0);
            check_eq("rst_count", 64'(count[i]), 64'd0);
        end

        // Sparse counts at 3, 7, 15.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) mem[i][k] = 64'd0;
            mem[i][3]  = {32'hdead0003, 32'd5};
            mem[i][7]  = {32'h0, 32'd1};
            mem[i][15] = {32'h1234abcd, 32'd9};
        end
        sweep(1'b0, 1'b0);

        // Dense k+100, full rate then random backpressure.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < N; k++) mem[i][k] = 64'(k + 100);
        sweep(1'b0, 1'b0);
        sweep(1'b1, 1'b0);

        // All-zero memory.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < N; k++) mem[i][k] = 64'd0;
        sweep(1'b0, 1'b0);

        // Reset mid-sweep, then a clean resweep.
        fill_random();
        reset_mid_sweep();
        sweep(1'b0, 1'b0);

        // Stray start pulses during a sweep, then a later accepted start.
        fill_random();
        sweep(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        fill_random();
        sweep(1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            sweep(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
